ins_seq: RTL and testbench

Instruction sequencer that feeds opcodes to the instruction decoder of the 4-bit microprocessor. It holds a small program store, keeps a program counter, and issues one 4-bit opcode at a time on RI_o with a valid/ack handshake to the execute side. It interprets the flow-control opcodes (HOLD, RST, UNAB and illegal codes) itself. It drives UNAB whenever no instruction is being issued, so the decoder's one-hot output is all zeros.

---
 rtl/ins_pkg.sv | 27 ++
 rtl/ins_mem.sv | 23 ++
 rtl/ins_seq.sv | 133 +++++++++++++
 tb/tb_ins_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// rtl/ins_pkg.sv - opcode constants, sequencer states and helpers shared by sequencer and decoder
package ins_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SUMA = 4'd3;
    localparam logic [3:0] OP_INV  = 4'd4;
    localparam logic [3:0] OP_HOLD = 4'd5;
    localparam logic [3:0] OP_LOAD = 4'd6;
    localparam logic [3:0] OP_RST  = 4'd7;
    localparam logic [3:0] OP_UNAB = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // UNAB shares the >= 8 range with the illegal codes: both halt the sequencer
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/ins_mem.sv
// rtl/ins_mem.sv - DEPTH x 4 program store, synchronous write, asynchronous read
module ins_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [3:0]               wdat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [3:0]               rdat
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/ins_seq.sv
// rtl/ins_seq.sv - instruction sequencer with program store; ISEQ_RETCNT_EN adds ret_cnt_o
module ins_seq
    import ins_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int HOLD_CYC = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [3:0]               prog_dat_i,
    input  logic                     ack_i,
    output logic [3:0]               RI_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH)-1:0] pc_o,
`ifdef ISEQ_RETCNT_EN
    output logic [15:0]              ret_cnt_o,
`endif
    output logic                     halted_o
);

    localparam int AW = $clog2(DEPTH);

    seq_state_t    state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [3:0]    ir, ir_n;
    logic [7:0]    hold_cnt, hold_n;
    logic [3:0]    mem_rdat;
    logic          issuing;
    logic          acked;

    ins_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i (clk_i),
        .we    (prog_we_i && (state == IDLE)),
        .waddr (prog_addr_i),
        .wdat  (prog_dat_i),
        .raddr (pc),
        .rdat  (mem_rdat)
    );

    // a halting code sitting in IR is never presented to the decoder
    assign issuing = (state == ISSUE) && !is_illegal(ir);
    assign acked   = issuing && ack_i && !stop_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= OP_UNAB;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        hold_n  = hold_cnt;
        if (stop_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        pc_n    = '0;
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    ir_n    = mem_rdat;
                    state_n = ISSUE;
                end
                ISSUE: begin
                    if (is_illegal(ir)) begin
                        state_n = HALT;
                    end else if (ack_i) begin
                        if (ir == OP_RST) begin
                            pc_n    = '0;
                            state_n = FETCH;
                        end else if (ir == OP_HOLD) begin
                            pc_n    = pc + AW'(1);
                            hold_n  = 8'(HOLD_CYC);
                            state_n = WAIT;
                        end else begin
                            pc_n    = pc + AW'(1);
                            state_n = FETCH;
                        end
                    end
                end
                WAIT: begin
                    if (hold_cnt <= 8'd1) begin
                        hold_n  = '0;
                        state_n = FETCH;
                    end else begin
                        hold_n = hold_cnt - 8'd1;
                    end
                end
                HALT:    state_n = HALT;
                default: state_n = IDLE;
            endcase
        end
    end

    assign RI_o     = issuing ? ir : OP_UNAB;
    assign valid_o  = issuing;
    assign pc_o     = pc;
    assign halted_o = (state == HALT);

`ifdef ISEQ_RETCNT_EN
    logic [15:0] ret_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ret_cnt <= '0;
        end else if ((state == IDLE) && start_i && !stop_i) begin
            ret_cnt <= '0;
        end else if (acked && (ret_cnt != 16'hFFFF)) begin
            ret_cnt <= ret_cnt + 16'd1;
        end
    end

    assign ret_cnt_o = ret_cnt;
`endif

endmodule

// File: tb/tb_ins_seq.sv
// tb/tb_ins_seq.sv - directed scoreboard bench for ins_seq
module tb_ins_seq;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_dat;
    logic          ack;
    logic [3:0]    ri;
    logic          valid;
    logic [AW-1:0] pc;
    logic          halted;
`ifdef ISEQ_RETCNT_EN
    logic [15:0]   ret_cnt;
`endif

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ins_seq #(.DEPTH(DEPTH), .HOLD_CYC(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_dat_i  (prog_dat),
        .ack_i       (ack),
        .RI_o        (ri),
        .valid_o     (valid),
        .pc_o        (pc),
`ifdef ISEQ_RETCNT_EN
        .ret_cnt_o   (ret_cnt),
`endif
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic prog(input int addr, input logic [3:0] dat);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_dat  = dat;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input int p);
        exp_t e;
        e.op = op;
        e.pc = AW'(p);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // waits (bounded) for the next issue, scores it, then lets the ack edge pass
    task automatic expect_issue(input bit stop_with_ack, output int waited);
        exp_t e;
        waited = 0;
        while (!valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("issue_seen", 32'(valid), 32'd1);
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("issue_op", 32'(ri), 32'(e.op));
                chk("issue_pc", 32'(pc), 32'(e.pc));
            end
        end
        if (stop_with_ack) stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_dat = '0; ack = 1'b0;
        #1;
        chk("rst_ri", 32'(ri), 32'h8);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #12 rst_n = 1'b1;
        tick();

        // straight-line program ending in UNAB
        prog(0, 4'd0); prog(1, 4'd1); prog(2, 4'd2); prog(3, 4'd8);
        push(4'd0, 0); push(4'd1, 1); push(4'd2, 2);
        ack = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            expect_issue(1'b0, w);
            chk("gap_t2", 32'(w), 32'd1);
        end
        w = 0;
        while (!halted && w < 10) begin
            chk("unab_no_valid", 32'(valid), 32'd0);
            tick();
            w++;
        end
        chk("halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd3);
        chk("halt_ri", 32'(ri), 32'h8);
        chk("halt_valid", 32'(valid), 32'd0);
        tick();
        chk("halt_sticky", 32'(halted), 32'd1);
        pulse_stop();
        chk("stop_idle", 32'(halted), 32'd0);
        chk("stop_pc", 32'(pc), 32'd3);

        // RST loop: 3,7 repeating, pc never passes 1
        prog(0, 4'd3); prog(1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            push(4'd3, 0);
            push(4'd7, 1);
        end
        pulse_start();
        for (int i = 0; i < 6; i++) expect_issue(1'b0, w);
        ack = 1'b0;
        pulse_stop();

        // HOLD stalls for HOLD_CYC plus one fetch
        prog(0, 4'd5); prog(1, 4'd4); prog(2, 4'd8);
        push(4'd5, 0); push(4'd4, 1);
        ack = 1'b1;
        pulse_start();
        expect_issue(1'b0, w);
        expect_issue(1'b0, w);
        chk("hold_gap", 32'(w), 32'd5);
        tick(); tick();
        chk("hold_halted", 32'(halted), 32'd1);
        chk("hold_halt_pc", 32'(pc), 32'd2);
        pulse_stop();

        // full store of ANDs: pc wraps, then stop beats ack at pc 5
        for (int a = 0; a < DEPTH; a++) prog(a, 4'd0);
        for (int i = 0; i < DEPTH + 5; i++) push(4'd0, i % DEPTH);
        push(4'd0, 5);
        pulse_start();
        for (int i = 0; i < DEPTH + 5; i++) expect_issue(1'b0, w);
        expect_issue(1'b1, w);
        chk("stopack_valid", 32'(valid), 32'd0);
        chk("stopack_pc", 32'(pc), 32'd5);
        chk("stopack_halted", 32'(halted), 32'd0);
        tick(); tick();
        chk("stopack_idle", 32'(valid), 32'd0);
        chk("stopack_pc_hold", 32'(pc), 32'd5);

`ifdef ISEQ_RETCNT_EN
        pulse_start();
        chk("retcnt_clr", 32'(ret_cnt), 32'd0);
        for (int i = 0; i < 10; i++) push(4'd0, i);
        for (int i = 0; i < 10; i++) expect_issue(1'b0, w);
        chk("retcnt_10", 32'(ret_cnt), 32'd10);
        ack = 1'b0;
        pulse_stop();
        pulse_start();
        chk("retcnt_start_clr", 32'(ret_cnt), 32'd0);
        pulse_stop();
`endif

        // no ack: output held stable, then async reset mid-ISSUE
        prog(0, 4'd2); prog(1, 4'd8);
        ack = 1'b0;
        pulse_start();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("stall_ri", 32'(ri), 32'd2);
            chk("stall_valid", 32'(valid), 32'd1);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ri", 32'(ri), 32'h8);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(4'd2, 0);
        ack = 1'b1;
        pulse_start();
        expect_issue(1'b0, w);
        tick(); tick(); tick();
        chk("keep_halt", 32'(halted), 32'd1);
        chk("keep_pc", 32'(pc), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
